// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int ALIGN_BITS = 3;
  localparam int DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Doubleword index portion of a byte address.
  function automatic logic [DATA_W-ALIGN_BITS-1:0] word_index(input logic [DATA_W-1:0] addr);
    return addr[DATA_W-1:ALIGN_BITS];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU data port (master) and the responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port doubleword storage: synchronous write, combinational read at the same index.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Commit a store on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_STATES extra
// cycles, response held until consumed. Optional DMEM_STATS_EN adds saturating
// load/store completion counters.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down wait states
// RESP  | response presented, waiting for resp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count
`endif
);

  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WORD_AW = DATA_W - ALIGN_BITS;
  localparam logic [WORD_AW-1:0] DEPTH_LIM = WORD_AW'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  state_e            state;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [DATA_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              eff_write;
  logic [DATA_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              eff_error;
  logic              enter_resp;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] load_rdata;

  // With no wait states RESP is entered on the accept edge, before the capture
  // registers are loaded, so the live bus fields feed the access in IDLE.
  always_comb begin
    if (state == IDLE) begin
      eff_write = bus.req_write;
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
    end else begin
      eff_write = cap_write;
      eff_addr  = cap_addr;
      eff_wdata = cap_wdata;
    end
  end

  assign eff_error  = (eff_addr[ALIGN_BITS-1:0] != '0) || (word_index(eff_addr) >= DEPTH_LIM);
  assign enter_resp = (state == IDLE) ? (NO_WAIT && bus.req_valid)
                                      : ((state == WAIT) && (cnt == 4'd0));
  assign mem_idx    = eff_addr[ALIGN_BITS +: IDX_W];
  assign mem_we     = enter_resp && eff_write && !eff_error;
  assign load_rdata = (eff_write || eff_error) ? '0 : mem_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (eff_wdata),
    .rdata (mem_rdata)
  );

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef DMEM_STATS_EN
      rd_count     <= 32'd0;
      wr_count     <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write   <= bus.req_write;
            cap_addr    <= bus.req_addr;
            cap_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (NO_WAIT) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= load_rdata;
              resp_error_q <= eff_error;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_rdata;
            resp_error_q <= eff_error;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
`ifdef DMEM_STATS_EN
            if (!resp_error_q) begin
              if (cap_write) begin
                if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
              end else begin
                if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
              end
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule
